// File: rtl/seg_scan_if.sv
// Bundle for seg_scan_display: datapath-side display request and the
// board-side segment/anode drive.
interface seg_scan_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] digits_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   blink_mask;
   logic                blank_lz;
   logic [3:0]          error;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame_tick;

   modport master (
      output digits_in, dp_in, blink_mask, blank_lz, error,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  digits_in, dp_in, blink_mask, blank_lz, error,
      output seg, dp, an, frame_tick
   );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scan driver with decimal points, leading-zero
// blanking, blinking, anti-ghost guard interval and a frame-coherent error overlay.
module seg_scan_display #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned DIV_BITS   = 17,
   parameter int unsigned GUARD      = 2,
   parameter int unsigned BLINK_BITS = 6
) (
   input  logic      clk,
   input  logic      rst_n,
   seg_scan_if.slave bus
);

   localparam int unsigned IW    = $clog2(DIGITS);
   localparam logic [IW-1:0] LAST  = IW'(DIGITS - 1);
   localparam logic [IW-1:0] ERR_R1 = IW'(DIGITS - 2);
   localparam logic [IW-1:0] ERR_R2 = IW'(DIGITS - 3);
   localparam logic [DIV_BITS-1:0] GLOAD = DIV_BITS'((GUARD > 0) ? GUARD - 1 : 0);

   typedef enum logic [1:0] {ST_RESET, ST_GUARD, ST_ON} state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
         4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
         4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
         4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
      endcase
      return s;
   endfunction

   logic [DIV_BITS-1:0]   presc;
   logic                  tick;
   logic [IW-1:0]         idx, nidx;
   logic                  boundary;

   logic [4*DIGITS-1:0]   snap_digits;
   logic [DIGITS-1:0]     snap_dp, snap_blink;
   logic                  snap_lz;
   logic [3:0]            snap_err;
   logic [BLINK_BITS-1:0] fcnt, fcnt_inc;

   logic [4*DIGITS-1:0]   src_digits;
   logic [DIGITS-1:0]     src_dp, src_blink;
   logic                  src_lz;
   logic [3:0]            src_err;
   logic                  phase;
   logic [DIGITS-1:0]     lz_blank;
   logic                  zero_run;
   logic                  blanked;
   logic [6:0]            seg_nx;
   logic                  dp_nx;

   logic [6:0]            seg_q;
   logic                  dp_q;
   logic                  ft_q;

   state_t                state, state_nx;
   logic [DIGITS-1:0]     an_q, an_nx;
   logic [DIV_BITS-1:0]   gcnt, gcnt_nx;

   assign tick     = &presc;
   assign nidx     = (idx == LAST) ? '0 : idx + 1'b1;
   assign boundary = tick && (idx == LAST);
   assign fcnt_inc = fcnt + 1'b1;

   // On the frame boundary the glyph is decoded straight from the live inputs
   // being captured, so the first digit of a frame carries no extra latency.
   always_comb begin
      src_digits = boundary ? bus.digits_in  : snap_digits;
      src_dp     = boundary ? bus.dp_in      : snap_dp;
      src_blink  = boundary ? bus.blink_mask : snap_blink;
      src_lz     = boundary ? bus.blank_lz   : snap_lz;
      src_err    = boundary ? bus.error      : snap_err;
      phase      = boundary ? fcnt_inc[BLINK_BITS-1] : fcnt[BLINK_BITS-1];

      lz_blank = '0;
      zero_run = 1'b1;
      for (int unsigned k = 1; k < DIGITS; k++) begin
         zero_run = zero_run && (src_digits[4*(DIGITS-k) +: 4] == 4'h0);
         lz_blank[DIGITS-k] = zero_run;
      end

      blanked = (src_lz && lz_blank[nidx]) || (phase && src_blink[nidx]);
      seg_nx  = '0;
      dp_nx   = 1'b0;
      if (src_err != 4'h0) begin
         if (nidx == LAST)
            seg_nx = 7'h4F;
         else if (nidx == ERR_R1 || nidx == ERR_R2)
            seg_nx = 7'h05;
         else if (nidx == '0)
            seg_nx = seg_decode(src_err);
      end else if (!blanked) begin
         seg_nx = seg_decode(src_digits[{nidx, 2'b00} +: 4]);
         dp_nx  = src_dp[nidx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc       <= '0;
         idx         <= LAST;
         fcnt        <= '0;
         snap_digits <= '0;
         snap_dp     <= '0;
         snap_blink  <= '0;
         snap_lz     <= 1'b0;
         snap_err    <= '0;
         seg_q       <= '0;
         dp_q        <= 1'b0;
         ft_q        <= 1'b0;
      end else begin
         presc <= presc + 1'b1;
         ft_q  <= boundary;
         if (tick) begin
            idx   <= nidx;
            seg_q <= seg_nx;
            dp_q  <= dp_nx;
         end
         if (boundary) begin
            fcnt        <= fcnt_inc;
            snap_digits <= bus.digits_in;
            snap_dp     <= bus.dp_in;
            snap_blink  <= bus.blink_mask;
            snap_lz     <= bus.blank_lz;
            snap_err    <= bus.error;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RESET;
         an_q  <= '1;
         gcnt  <= '0;
      end else begin
         state <= state_nx;
         an_q  <= an_nx;
         gcnt  <= gcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      an_nx    = an_q;
      gcnt_nx  = gcnt;
      if (tick) begin
         an_nx = '1;
         if (GUARD == 0) begin
            state_nx    = ST_ON;
            an_nx[nidx] = 1'b0;
         end else begin
            state_nx = ST_GUARD;
            gcnt_nx  = GLOAD;
         end
      end else begin
         case (state)
            ST_GUARD: begin
               if (gcnt == '0) begin
                  state_nx   = ST_ON;
                  an_nx      = '1;
                  an_nx[idx] = 1'b0;
               end else begin
                  gcnt_nx = gcnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = ft_q;

endmodule
